spi_cmd_decoder: RTL

Consumes 16-bit words from the SPI slave receiver (one word per SSEL transaction) and returns its response via the `sendme` word that the receiver latches at the start of the next transaction. It implements a small command protocol: control-register writes and reads, a memory pointer load, and burst reads from a 16-bit memory such as the capture buffer. It sits between the SPI slave and the control/capture logic.

---
 rtl/spi_cmd_decoder.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/spi_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : spi_cmd_decoder
//  Purpose  : Command decoder behind an SPI slave receiver. Each received
//             16-bit word is decoded as a command (or as the data word of a
//             pending command). The response is placed in `sendme` and is
//             shifted out by the slave in the following transaction.
//             Commands: NOP, WRITE_REG, READ_REG, SET_PTR, READ_MEM (burst).
//  Ports    : clk, rst          - clock, asynchronous active-high reset
//             word_valid/data   - received word strobe and payload
//             sendme            - response word for the next transaction
//             ctrl_regs         - control registers 0..6, 16 bits each
//             status_in         - read-only value returned as register 7
//             mem_addr/rd       - memory read request (one outstanding)
//             mem_rdata/rvalid  - memory read response
//             busy              - high while a command is in progress
//  Revision : 1.0 - initial release
// ============================================================================
module spi_cmd_decoder #(
    parameter int          ADDR_W  = 16,
    parameter logic [23:0] TIMEOUT = 24'd1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              word_valid,
    input  logic [15:0]       word_data,
    output logic [15:0]       sendme,
    output logic [111:0]      ctrl_regs,
    input  logic [15:0]       status_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_rvalid,
    output logic              busy
);

    localparam logic [3:0] c_OP_WR_REG  = 4'h1;
    localparam logic [3:0] c_OP_RD_REG  = 4'h2;
    localparam logic [3:0] c_OP_RD_MEM  = 4'h3;
    localparam logic [3:0] c_OP_SET_PTR = 4'h4;
    localparam logic [2:0] c_STATUS_IDX = 3'd7;
    localparam int         c_EXT_W      = (ADDR_W > 16) ? ADDR_W : 16;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WR_DATA    = 3'd1,
        S_PTR_DATA   = 3'd2,
        S_MEM_REQ    = 3'd3,
        S_MEM_WAIT   = 3'd4,
        S_MEM_STREAM = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [15:0]         r_sendme;
    logic [15:0]         r_regs [0:6];
    logic [2:0]          r_wr_addr;
    logic [ADDR_W-1:0]   r_ptr;
    logic [11:0]         r_remaining;
    logic [23:0]         r_idle_cnt;

    logic [3:0]          w_opcode;
    logic [11:0]         w_arg;
    logic [15:0]         w_reg_rd_data;
    logic [c_EXT_W-1:0]  w_word_ext;
    logic                w_timeout;
    logic                w_sendme_we;
    logic [15:0]         w_sendme_d;
    logic                w_wr_addr_load;
    logic                w_reg_we;
    logic                w_ptr_load;
    logic                w_ptr_inc;
    logic                w_rem_load;
    logic                w_rem_dec;

    assign w_opcode   = word_data[15:12];
    assign w_arg      = word_data[11:0];
    assign w_word_ext = c_EXT_W'(word_data);
    assign w_timeout  = (r_idle_cnt >= TIMEOUT);

    // Register read mux; address 7 maps to the external status word.
    always_comb begin
        w_reg_rd_data = status_in;
        for (int i = 0; i < 7; i++) begin
            if (w_arg[2:0] == 3'(i)) begin
                w_reg_rd_data = r_regs[i];
            end
        end
    end

    // Next-state and datapath control
    always_comb begin
        w_state_next   = r_state;
        w_sendme_we    = 1'b0;
        w_sendme_d     = 16'h0000;
        w_wr_addr_load = 1'b0;
        w_reg_we       = 1'b0;
        w_ptr_load     = 1'b0;
        w_ptr_inc      = 1'b0;
        w_rem_load     = 1'b0;
        w_rem_dec      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (word_valid) begin
                    case (w_opcode)
                        c_OP_WR_REG: begin
                            w_wr_addr_load = 1'b1;
                            w_state_next   = S_WR_DATA;
                        end
                        c_OP_RD_REG: begin
                            w_sendme_we = 1'b1;
                            w_sendme_d  = w_reg_rd_data;
                        end
                        c_OP_SET_PTR: begin
                            w_state_next = S_PTR_DATA;
                        end
                        c_OP_RD_MEM: begin
                            if (w_arg == 12'd0) begin
                                w_sendme_we = 1'b1;
                            end else begin
                                w_rem_load   = 1'b1;
                                w_state_next = S_MEM_REQ;
                            end
                        end
                        default: begin
                            w_sendme_we = 1'b1;
                        end
                    endcase
                end
            end
            S_WR_DATA: begin
                if (word_valid) begin
                    w_reg_we     = (r_wr_addr != c_STATUS_IDX);
                    w_state_next = S_IDLE;
                end else if (w_timeout) begin
                    w_sendme_we  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_PTR_DATA: begin
                if (word_valid) begin
                    w_ptr_load   = 1'b1;
                    w_state_next = S_IDLE;
                end else if (w_timeout) begin
                    w_sendme_we  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_MEM_REQ: begin
                w_ptr_inc    = 1'b1;
                w_state_next = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                // Host words arriving here are overruns and are dropped.
                if (mem_rvalid) begin
                    w_sendme_we  = 1'b1;
                    w_sendme_d   = mem_rdata;
                    w_rem_dec    = 1'b1;
                    w_state_next = (r_remaining == 12'd1) ? S_IDLE : S_MEM_STREAM;
                end
            end
            S_MEM_STREAM: begin
                if (word_valid) begin
                    w_state_next = S_MEM_REQ;
                end else if (w_timeout) begin
                    w_sendme_we  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sendme    <= 16'h0000;
            r_wr_addr   <= 3'd0;
            r_ptr       <= '0;
            r_remaining <= 12'd0;
            r_idle_cnt  <= 24'd0;
            for (int i = 0; i < 7; i++) begin
                r_regs[i] <= 16'h0000;
            end
        end else begin
            if (w_sendme_we) begin
                r_sendme <= w_sendme_d;
            end
            if (w_wr_addr_load) begin
                r_wr_addr <= w_arg[2:0];
            end
            for (int i = 0; i < 7; i++) begin
                if (w_reg_we && (r_wr_addr == 3'(i))) begin
                    r_regs[i] <= word_data;
                end
            end
            if (w_ptr_load) begin
                r_ptr <= w_word_ext[ADDR_W-1:0];
            end else if (w_ptr_inc) begin
                r_ptr <= r_ptr + 1'b1;
            end
            if (w_rem_load) begin
                r_remaining <= w_arg;
            end else if (w_rem_dec) begin
                r_remaining <= r_remaining - 12'd1;
            end
            // Counts clocks since the last host word; saturates so a stalled
            // memory cannot wrap it back below the threshold.
            if ((r_state == S_IDLE) || word_valid) begin
                r_idle_cnt <= 24'd0;
            end else if (!w_timeout) begin
                r_idle_cnt <= r_idle_cnt + 24'd1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_ctrl_regs
            assign ctrl_regs[16*gi +: 16] = r_regs[gi];
        end
    endgenerate

    // mem_addr tracks ptr, so it carries the request address while mem_rd is high.
    assign sendme   = r_sendme;
    assign mem_addr = r_ptr;
    assign mem_rd   = (r_state == S_MEM_REQ);
    assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire
